// File: rtl/tri_dispatch.sv
// tri_dispatch: queues triangle setup records and issues them one at a time to fragment_generator (optional perf counters: TRI_DISPATCH_PERF_EN)
module tri_dispatch #(
   parameter int LG_TRI_Q_SZ = 2,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tri_val,
   output logic             tri_rdy,
   input  logic [31:0]      tri_ymin,
   input  logic [31:0]      tri_ymax,
   input  logic [31:0]      tri_xmin,
   input  logic [31:0]      tri_xmax,
   input  logic [31:0]      tri_l0_dx,
   input  logic [31:0]      tri_l1_dx,
   input  logic [31:0]      tri_l2_dx,
   input  logic [31:0]      tri_l0_dy,
   input  logic [31:0]      tri_l1_dy,
   input  logic [31:0]      tri_l2_dy,
   input  logic [31:0]      tri_w0_00,
   input  logic [31:0]      tri_w1_00,
   input  logic [31:0]      tri_w2_00,
   output logic             fg_start,
   output logic [31:0]      fg_ymin,
   output logic [31:0]      fg_ymax,
   output logic [31:0]      fg_xmin,
   output logic [31:0]      fg_xmax,
   output logic [31:0]      fg_l0_dx,
   output logic [31:0]      fg_l1_dx,
   output logic [31:0]      fg_l2_dx,
   output logic [31:0]      fg_l0_dy,
   output logic [31:0]      fg_l1_dy,
   output logic [31:0]      fg_l2_dy,
   output logic [31:0]      fg_w0_00,
   output logic [31:0]      fg_w1_00,
   output logic [31:0]      fg_w2_00,
   input  logic             fg_done,
   output logic             busy,
   output logic [CNT_W-1:0] tris_issued,
   output logic [CNT_W-1:0] tris_dropped,
`ifdef TRI_DISPATCH_PERF_EN
   output logic [CNT_W-1:0] wait_cycles,
   output logic [CNT_W-1:0] full_stall_cycles,
`endif
   output logic             err_spurious
);
   localparam int DEPTH = 1 << LG_TRI_Q_SZ;
   localparam int REC_W = 13 * 32;
   typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;
   state_t state_q, state_d;
   logic [LG_TRI_Q_SZ:0] head, tail;
   logic [REC_W-1:0] mem [DEPTH];
   logic [REC_W-1:0] rec_in, head_rec, fg_rec;
   logic full, empty, push, pop, issue, drop, degen;
   assign rec_in = {tri_ymin, tri_ymax, tri_xmin, tri_xmax, tri_l0_dx, tri_l1_dx, tri_l2_dx,
                    tri_l0_dy, tri_l1_dy, tri_l2_dy, tri_w0_00, tri_w1_00, tri_w2_00};
   assign head_rec = mem[head[LG_TRI_Q_SZ-1:0]];
   assign full = (head[LG_TRI_Q_SZ] != tail[LG_TRI_Q_SZ]) && (head[LG_TRI_Q_SZ-1:0] == tail[LG_TRI_Q_SZ-1:0]);
   assign empty = head == tail;
   assign tri_rdy = !full;
   assign push = tri_val && !full;
   assign degen = (head_rec[383:352] <= head_rec[415:384]) || (head_rec[319:288] <= head_rec[351:320]);
   assign fg_start = state_q == START;
   assign busy = !empty || state_q != IDLE;
   assign {fg_ymin, fg_ymax, fg_xmin, fg_xmax, fg_l0_dx, fg_l1_dx, fg_l2_dx,
           fg_l0_dy, fg_l1_dy, fg_l2_dy, fg_w0_00, fg_w1_00, fg_w2_00} = fg_rec;
   // next state: pop in IDLE, drop degenerate boxes in place, one START cycle, then wait for done
   always_comb begin
      state_d = state_q;
      pop = 1'b0;
      issue = 1'b0;
      drop = 1'b0;
      if (state_q == IDLE && !empty) begin
         pop = 1'b1;
         drop = degen;
         issue = !degen;
         state_d = degen ? IDLE : START;
      end else if (state_q == START) begin
         state_d = WAIT_DONE;
      end else if (state_q == WAIT_DONE && fg_done) begin
         state_d = IDLE;
      end
   end
   // state register
   always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
   // queue pointers; a full queue refuses pushes even when popping
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (push) tail <= tail + (LG_TRI_Q_SZ+1)'(1);
         if (pop) head <= head + (LG_TRI_Q_SZ+1)'(1);
      end
   end
   // queue storage needs no reset; only pointers define validity
   always_ff @(posedge clk) if (push) mem[tail[LG_TRI_Q_SZ-1:0]] <= rec_in;
   // setup fields held from issue until the next issue
   always_ff @(posedge clk) fg_rec <= rst ? '0 : issue ? head_rec : fg_rec;
   // statistics and sticky error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         tris_issued <= '0;
         tris_dropped <= '0;
         err_spurious <= 1'b0;
      end else begin
         if (state_q == START) tris_issued <= tris_issued + CNT_W'(1);
         if (drop) tris_dropped <= tris_dropped + CNT_W'(1);
         if (fg_done && state_q != WAIT_DONE) err_spurious <= 1'b1;
      end
   end
`ifdef TRI_DISPATCH_PERF_EN
   // wait and back-pressure cycle counters
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cycles <= '0;
         full_stall_cycles <= '0;
      end else begin
         if (state_q == WAIT_DONE) wait_cycles <= wait_cycles + CNT_W'(1);
         if (tri_val && full) full_stall_cycles <= full_stall_cycles + CNT_W'(1);
      end
   end
`endif
endmodule

// File: tb/tb_tri_dispatch.sv
// tb_tri_dispatch: directed self-checking bench for tri_dispatch
module tb_tri_dispatch;
   logic clk = 1'b0, rst = 1'b1, tri_val = 1'b0, fg_done = 1'b0;
   logic [31:0] ymin = 0, ymax = 0, xmin = 0, xmax = 0, l0_dx = 0, l1_dx = 0, l2_dx = 0;
   logic [31:0] l0_dy = 0, l1_dy = 0, l2_dy = 0, w0 = 0, w1 = 0, w2 = 0;
   logic tri_rdy, fg_start, busy, err_spurious;
   logic [31:0] fg_ymin, fg_ymax, fg_xmin, fg_xmax, fg_l0_dx, fg_l1_dx, fg_l2_dx;
   logic [31:0] fg_l0_dy, fg_l1_dy, fg_l2_dy, fg_w0_00, fg_w1_00, fg_w2_00;
   logic [31:0] tris_issued, tris_dropped;
`ifdef TRI_DISPATCH_PERF_EN
   logic [31:0] wait_cycles, full_stall_cycles;
`endif
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   tri_dispatch dut (
      .clk(clk), .rst(rst), .tri_val(tri_val), .tri_rdy(tri_rdy),
      .tri_ymin(ymin), .tri_ymax(ymax), .tri_xmin(xmin), .tri_xmax(xmax),
      .tri_l0_dx(l0_dx), .tri_l1_dx(l1_dx), .tri_l2_dx(l2_dx),
      .tri_l0_dy(l0_dy), .tri_l1_dy(l1_dy), .tri_l2_dy(l2_dy),
      .tri_w0_00(w0), .tri_w1_00(w1), .tri_w2_00(w2),
      .fg_start(fg_start), .fg_ymin(fg_ymin), .fg_ymax(fg_ymax), .fg_xmin(fg_xmin), .fg_xmax(fg_xmax),
      .fg_l0_dx(fg_l0_dx), .fg_l1_dx(fg_l1_dx), .fg_l2_dx(fg_l2_dx),
      .fg_l0_dy(fg_l0_dy), .fg_l1_dy(fg_l1_dy), .fg_l2_dy(fg_l2_dy),
      .fg_w0_00(fg_w0_00), .fg_w1_00(fg_w1_00), .fg_w2_00(fg_w2_00),
      .fg_done(fg_done), .busy(busy), .tris_issued(tris_issued), .tris_dropped(tris_dropped),
`ifdef TRI_DISPATCH_PERF_EN
      .wait_cycles(wait_cycles), .full_stall_cycles(full_stall_cycles),
`endif
      .err_spurious(err_spurious)
   );
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic set_rec(input logic [31:0] y0, y1, x0, x1, w);
      ymin = y0; ymax = y1; xmin = x0; xmax = x1; w0 = w;
      l0_dx = w + 1; l1_dx = w + 2; l2_dx = w + 3;
      l0_dy = w + 4; l1_dy = w + 5; l2_dy = w + 6;
      w1 = w + 7; w2 = w + 8;
   endtask
   task automatic push(input logic [31:0] y0, y1, x0, x1, w);
      set_rec(y0, y1, x0, x1, w);
      tri_val = 1'b1;
      tick;
      tri_val = 1'b0;
   endtask
   task automatic done_pulse(input logic [31:0] prev, input bit nxt, input logic [31:0] ny);
      fg_done = 1'b1;
      tick;
      fg_done = 1'b0;
      chk("hold_start", fg_start, 0);
      chk("hold_ymin", fg_ymin, prev);
      if (nxt) begin
         tick;
         chk("next_start", fg_start, 1);
         chk("next_ymin", fg_ymin, ny);
         tick;
      end
   endtask
   initial begin
      tick;
      tick;
      chk("rst_rdy", tri_rdy, 1);
      chk("rst_busy", busy, 0);
      chk("rst_start", fg_start, 0);
      chk("rst_issued", tris_issued, 0);
      chk("rst_dropped", tris_dropped, 0);
      chk("rst_err", err_spurious, 0);
      chk("rst_w0", fg_w0_00, 0);
      rst = 1'b0;
      tick;
      push(0, 2, 0, 3, 32'h3f800000);
      chk("t1_start_early", fg_start, 0);
      chk("t1_busy", busy, 1);
      tick;
      chk("t1_start", fg_start, 1);
      chk("t1_w0", fg_w0_00, 32'h3f800000);
      chk("t1_xmax", fg_xmax, 3);
      chk("t1_ymax", fg_ymax, 2);
      chk("t1_l2_dy", fg_l2_dy, 32'h3f800006);
      chk("t1_w2", fg_w2_00, 32'h3f800008);
      tick;
      chk("t1_start_once", fg_start, 0);
      chk("t1_issued", tris_issued, 1);
      tick;
      tick;
      chk("t1_wait_start", fg_start, 0);
      done_pulse(0, 0, 0);
      chk("t1_idle_busy", busy, 0);
      chk("t1_err", err_spurious, 0);
      set_rec(3, 7, 5, 5, 1);
      tri_val = 1'b1;
      tick;
      set_rec(1, 4, 2, 6, 32'h40000000);
      tick;
      tri_val = 1'b0;
      chk("deg_dropped", tris_dropped, 1);
      chk("deg_no_start", fg_start, 0);
      chk("deg_xmax_kept", fg_xmax, 3);
      tick;
      chk("deg_next_start", fg_start, 1);
      chk("deg_next_xmax", fg_xmax, 6);
      chk("deg_next_w0", fg_w0_00, 32'h40000000);
      tick;
      chk("deg_issued", tris_issued, 2);
      done_pulse(1, 0, 0);
      chk("deg_busy", busy, 0);
      for (int k = 1; k <= 5; k++) begin
         push(k, k + 10, 0, 1, k);
         chk("fill_rdy", tri_rdy, (k < 5) ? 1 : 0);
      end
      set_rec(6, 16, 0, 1, 6);
      tri_val = 1'b1;
      tick;
      tick;
      tri_val = 1'b0;
      chk("full_rdy", tri_rdy, 0);
`ifdef TRI_DISPATCH_PERF_EN
      chk("full_stall", full_stall_cycles, 2);
`endif
      chk("full_issued", tris_issued, 3);
      done_pulse(1, 1, 2);
      done_pulse(2, 1, 3);
      done_pulse(3, 1, 4);
      done_pulse(4, 1, 5);
      done_pulse(5, 0, 0);
      chk("full_drained", busy, 0);
      chk("full_issued2", tris_issued, 7);
      for (int k = 20; k <= 23; k++) push(k, k + 1, 0, 1, k);
      chk("pp_rdy3", tri_rdy, 1);
      set_rec(24, 25, 0, 1, 24);
      fg_done = 1'b1;
      tick;
      fg_done = 1'b0;
      tri_val = 1'b1;
      tick;
      tri_val = 1'b0;
      chk("pp_occ3_rdy", tri_rdy, 1);
      chk("pp_start", fg_start, 1);
      chk("pp_ymin", fg_ymin, 21);
      push(25, 26, 0, 1, 25);
      chk("pp_full", tri_rdy, 0);
      done_pulse(21, 1, 22);
      done_pulse(22, 1, 23);
      done_pulse(23, 1, 24);
      done_pulse(24, 1, 25);
      done_pulse(25, 0, 0);
      chk("pp_busy", busy, 0);
      chk("pp_issued", tris_issued, 13);
      chk("sp_err0", err_spurious, 0);
      fg_done = 1'b1;
      tick;
      fg_done = 1'b0;
      chk("sp_err", err_spurious, 1);
      chk("sp_busy", busy, 0);
      chk("sp_issued", tris_issued, 13);
      tick;
      chk("sp_sticky", err_spurious, 1);
      for (int k = 30; k <= 33; k++) push(k, k + 1, 0, 1, k);
      chk("mr_busy", busy, 1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("mr_rdy", tri_rdy, 1);
      chk("mr_busy0", busy, 0);
      chk("mr_issued", tris_issued, 0);
      chk("mr_dropped", tris_dropped, 0);
      chk("mr_err", err_spurious, 0);
      chk("mr_start", fg_start, 0);
      chk("mr_ymin", fg_ymin, 0);
      tick;
      tick;
      chk("mr_idle_busy", busy, 0);
      chk("mr_idle_start", fg_start, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
